// File: rtl/prio_encoder_arb.sv
// Registered priority encoder / arbiter with a one-entry valid/ready output stage.
// Fixed mode grants the highest set bit; round-robin mode searches downward from ptr-1 with wrap.
module prio_encoder_arb #(
    parameter int WIDTH = 16,
    parameter bit RR    = 1'b0,
    parameter int IDXW  = $clog2(WIDTH),
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_none,
    output logic [CNTW-1:0]  out_count
);

    logic            out_valid_q, out_valid_d;
    logic [IDXW-1:0] out_idx_q, out_idx_d;
    logic            out_none_q, out_none_d;
    logic [CNTW-1:0] out_count_q, out_count_d;
    logic [IDXW-1:0] ptr_q, ptr_d;

    logic [IDXW-1:0] grant_idx;
    logic            grant_found;
    logic [CNTW-1:0] pop;
    logic            accept;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + CNTW'(req[i]);
        end
    end

    assign grant_found = |req;

    generate
        if (RR) begin : g_rr
            // Walk offsets from far to near so the nearest set bit below ptr overwrites the rest.
            always_comb begin
                grant_idx = '0;
                for (int k = WIDTH; k >= 1; k--) begin
                    if (req[(int'(ptr_q) + WIDTH - k) % WIDTH]) begin
                        grant_idx = IDXW'((int'(ptr_q) + WIDTH - k) % WIDTH);
                    end
                end
            end
        end else begin : g_fixed
            always_comb begin
                grant_idx = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (req[i]) begin
                        grant_idx = IDXW'(i);
                    end
                end
            end
        end
    endgenerate

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_none_d  = out_none_q;
        out_count_d = out_count_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_idx_d   = grant_idx;
            out_none_d  = !grant_found;
            out_count_d = pop;
            if (RR && grant_found) begin
                ptr_d = grant_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_none_q  <= 1'b0;
            out_count_q <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_none_q  <= out_none_d;
            out_count_q <= out_count_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_none  = out_none_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Directed bench for prio_encoder_arb: fixed mode, round-robin mode, and a 5-bit wrap-around instance.
module tb_prio_encoder_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Fixed-priority instance
    logic [15:0] f_req = '0;
    logic        f_iv = 1'b0, f_ordy = 1'b0, f_irdy, f_ov, f_none;
    logic [3:0]  f_idx;
    logic [4:0]  f_cnt;

    // Round-robin instance
    logic [15:0] r_req = '0;
    logic        r_iv = 1'b0, r_ordy = 1'b0, r_irdy, r_ov, r_none;
    logic [3:0]  r_idx;
    logic [4:0]  r_cnt;

    // Narrow round-robin instance
    logic [4:0]  w_req = '0;
    logic        w_iv = 1'b0, w_ordy = 1'b0, w_irdy, w_ov, w_none;
    logic [2:0]  w_idx;
    logic [2:0]  w_cnt;

    prio_encoder_arb #(.WIDTH(16), .RR(1'b0)) u_fix (
        .clk(clk), .rst(rst), .req(f_req), .in_valid(f_iv), .in_ready(f_irdy),
        .out_valid(f_ov), .out_ready(f_ordy), .out_idx(f_idx), .out_none(f_none), .out_count(f_cnt)
    );

    prio_encoder_arb #(.WIDTH(16), .RR(1'b1)) u_rr (
        .clk(clk), .rst(rst), .req(r_req), .in_valid(r_iv), .in_ready(r_irdy),
        .out_valid(r_ov), .out_ready(r_ordy), .out_idx(r_idx), .out_none(r_none), .out_count(r_cnt)
    );

    prio_encoder_arb #(.WIDTH(5), .RR(1'b1)) u_w5 (
        .clk(clk), .rst(rst), .req(w_req), .in_valid(w_iv), .in_ready(w_irdy),
        .out_valid(w_ov), .out_ready(w_ordy), .out_idx(w_idx), .out_none(w_none), .out_count(w_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    logic [15:0] bp_reqs [3] = '{16'h8000, 16'h0003, 16'hFFFF};
    int          rr_exp  [5] = '{15, 8, 0, 15, 8};
    int          w5_exp  [4] = '{4, 1, 0, 4};

    initial begin
        // Reset state while held in reset
        #2;
        check("rst_f_valid", 64'(f_ov), 64'd0);
        check("rst_f_idx",   64'(f_idx), 64'd0);
        check("rst_f_none",  64'(f_none), 64'd0);
        check("rst_f_count", 64'(f_cnt), 64'd0);
        check("rst_f_inrdy", 64'(f_irdy), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Fixed-priority encode
        f_iv = 1'b1; f_ordy = 1'b1; f_req = 16'h8001;
        step();
        check("fix_8001_valid", 64'(f_ov), 64'd1);
        check("fix_8001_idx",   64'(f_idx), 64'd15);
        check("fix_8001_count", 64'(f_cnt), 64'd2);
        check("fix_8001_none",  64'(f_none), 64'd0);

        // Empty input
        f_req = 16'h0000;
        step();
        check("fix_0000_valid", 64'(f_ov), 64'd1);
        check("fix_0000_none",  64'(f_none), 64'd1);
        check("fix_0000_idx",   64'(f_idx), 64'd0);
        check("fix_0000_count", 64'(f_cnt), 64'd0);

        f_req = 16'h0010;
        step();
        check("fix_0010_idx",   64'(f_idx), 64'd4);
        check("fix_0010_count", 64'(f_cnt), 64'd1);
        check("fix_0010_none",  64'(f_none), 64'd0);

        // Backpressure: accept 0x0100, then stall for 3 cycles
        f_req = 16'h0100;
        step();
        check("bp_first_idx", 64'(f_idx), 64'd8);
        f_ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f_req = bp_reqs[i];
            #1;
            check($sformatf("bp_hold%0d_inrdy", i), 64'(f_irdy), 64'd0);
            step();
            check($sformatf("bp_hold%0d_valid", i), 64'(f_ov), 64'd1);
            check($sformatf("bp_hold%0d_idx", i),   64'(f_idx), 64'd8);
            check($sformatf("bp_hold%0d_count", i), 64'(f_cnt), 64'd1);
        end
        f_ordy = 1'b1;
        f_req  = 16'hFFFF;
        #1;
        check("bp_release_inrdy", 64'(f_irdy), 64'd1);
        step();
        check("bp_new_valid", 64'(f_ov), 64'd1);
        check("bp_new_idx",   64'(f_idx), 64'd15);
        check("bp_new_count", 64'(f_cnt), 64'd16);
        f_iv = 1'b0;
        step();
        check("fix_drain_valid", 64'(f_ov), 64'd0);

        // Round-robin rotation
        r_iv = 1'b1; r_ordy = 1'b1; r_req = 16'h8101;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("rr_rot%0d_idx", i), 64'(r_idx), 64'(rr_exp[i]));
            check($sformatf("rr_rot%0d_count", i), 64'(r_cnt), 64'd3);
        end

        // Reset mid-operation (ptr is 8), pulsed between edges
        #3;
        rst = 1'b1;
        #1;
        check("rr_rst_valid", 64'(r_ov), 64'd0);
        check("rr_rst_idx",   64'(r_idx), 64'd0);
        #1;
        rst = 1'b0;
        step();
        check("rr_after_rst_idx",   64'(r_idx), 64'd15);
        check("rr_after_rst_valid", 64'(r_ov), 64'd1);

        // Single bit wins regardless of ptr; empty leaves ptr alone
        r_req = 16'h0004;
        step();
        check("rr_single_idx", 64'(r_idx), 64'd2);
        r_req = 16'h0000;
        step();
        check("rr_empty_none", 64'(r_none), 64'd1);
        check("rr_empty_idx",  64'(r_idx), 64'd0);
        r_req = 16'h8101;
        step();
        check("rr_after_empty_idx", 64'(r_idx), 64'd0);
        r_iv = 1'b0;

        // Wrap-around on a 5-bit instance
        w_iv = 1'b1; w_ordy = 1'b1; w_req = 5'b10011;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("w5_%0d_idx", i),   64'(w_idx), 64'(w5_exp[i]));
            check($sformatf("w5_%0d_count", i), 64'(w_cnt), 64'd3);
        end
        w_iv = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
